// File: rtl/load_writeback.sv
// load_writeback: MEM/WB stage producing the byte-enabled register-file write port.
// Define UNALIGNED_LOAD_EN to enable the LWL/LWR merge datapath (disabled by default).
module load_writeback (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        mem_valid,
  input  logic [3:0]  mem_wreg,
  input  logic [4:0]  mem_wraddr,
  input  logic [31:0] mem_alures,
  input  logic [2:0]  mem_ldop,
  input  logic [1:0]  mem_addr_lo,
  input  logic [31:0] mem_oldreg,
  input  logic        dresp_valid,
  input  logic [31:0] dresp_data,
  output logic        mem_stall,
  output logic [3:0]  we,
  output logic [4:0]  waddr,
  output logic [31:0] wdata
);

  typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_DRAIN} state_t;

  localparam logic [2:0] LD_NONE = 3'b000;
  localparam logic [2:0] LD_LB   = 3'b001;
  localparam logic [2:0] LD_LBU  = 3'b010;
  localparam logic [2:0] LD_LH   = 3'b011;
  localparam logic [2:0] LD_LHU  = 3'b100;
  localparam logic [2:0] LD_LW   = 3'b101;
  localparam logic [2:0] LD_LWL  = 3'b110;
  localparam logic [2:0] LD_LWR  = 3'b111;

  state_t      r_state;
  logic [2:0]  r_ldop;
  logic [1:0]  r_lo;
  logic [3:0]  r_wreg;
  logic [4:0]  r_wraddr;
  logic [3:0]  r_we;
  logic [4:0]  r_waddr;
  logic [31:0] r_wdata;

  logic        w_held;
  logic [2:0]  w_ldop;
  logic [1:0]  w_lo;
  logic [3:0]  w_wreg;
  logic [4:0]  w_wraddr;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [3:0]  w_alWe;
  logic [31:0] w_alData;
  logic        w_stall;

  // While waiting, the load context comes from the held copy, not from MEM.
  assign w_held   = (r_state == ST_WAIT);
  assign w_ldop   = w_held ? r_ldop   : mem_ldop;
  assign w_lo     = w_held ? r_lo     : mem_addr_lo;
  assign w_wreg   = w_held ? r_wreg   : mem_wreg;
  assign w_wraddr = w_held ? r_wraddr : mem_wraddr;

  assign w_byte = dresp_data[{w_lo, 3'b000} +: 8];
  assign w_half = w_lo[1] ? dresp_data[31:16] : dresp_data[15:0];

`ifdef UNALIGNED_LOAD_EN
  logic [31:0] r_oldreg;
  logic [31:0] w_old;
  logic [31:0] w_shData;
  logic [31:0] w_merged;
  logic [3:0]  w_mask;

  assign w_old = w_held ? r_oldreg : mem_oldreg;

  // LWL shifts the loaded bytes up into the top of the word, LWR shifts them down.
  always_comb begin
    w_shData = 32'h0;
    w_mask   = 4'h0;
    w_merged = w_old;
    if (w_ldop == LD_LWL) begin
      w_shData = dresp_data << {2'd3 - w_lo, 3'b000};
      w_mask   = 4'b1111 << (2'd3 - w_lo);
    end else begin
      w_shData = dresp_data >> {w_lo, 3'b000};
      w_mask   = 4'b1111 >> w_lo;
    end
    for (int i = 0; i < 4; i++) begin
      if (w_mask[i]) begin
        w_merged[8*i +: 8] = w_shData[8*i +: 8];
      end
    end
  end
`else
  logic w_unusedOld;
  assign w_unusedOld = ^mem_oldreg;
`endif

  always_comb begin
    w_alWe   = w_wreg;
    w_alData = dresp_data;
    case (w_ldop)
      LD_LB:   w_alData = {{24{w_byte[7]}}, w_byte};
      LD_LBU:  w_alData = {24'h0, w_byte};
      LD_LH:   w_alData = {{16{w_half[15]}}, w_half};
      LD_LHU:  w_alData = {16'h0, w_half};
      LD_LW:   w_alData = dresp_data;
`ifdef UNALIGNED_LOAD_EN
      LD_LWL, LD_LWR: begin
        w_alWe   = w_wreg & w_mask;
        w_alData = w_merged;
      end
`else
      LD_LWL, LD_LWR: w_alWe = 4'h0;
`endif
      default: w_alData = dresp_data;
    endcase
  end

  // DRAIN stalls even on the response cycle so a new MEM instruction is not lost.
  always_comb begin
    w_stall = 1'b0;
    case (r_state)
      ST_RUN:   w_stall = mem_valid & ~flush & (mem_ldop != LD_NONE) & ~dresp_valid;
      ST_WAIT:  w_stall = ~dresp_valid;
      ST_DRAIN: w_stall = 1'b1;
      default:  w_stall = 1'b0;
    endcase
  end

  assign mem_stall = w_stall & rst;
  assign we        = r_we;
  assign waddr     = r_waddr;
  assign wdata     = r_wdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_RUN;
      r_ldop   <= LD_NONE;
      r_lo     <= 2'b00;
      r_wreg   <= 4'h0;
      r_wraddr <= 5'h0;
      r_we     <= 4'h0;
      r_waddr  <= 5'h0;
      r_wdata  <= 32'h0;
`ifdef UNALIGNED_LOAD_EN
      r_oldreg <= 32'h0;
`endif
    end else begin
      case (r_state)
        ST_RUN: begin
          if (mem_valid && !flush) begin
            if (mem_ldop == LD_NONE) begin
              r_we    <= mem_wreg;
              r_waddr <= mem_wraddr;
              r_wdata <= mem_alures;
            end else if (dresp_valid) begin
              r_we    <= w_alWe;
              r_waddr <= w_wraddr;
              r_wdata <= w_alData;
            end else begin
              r_we     <= 4'h0;
              r_state  <= ST_WAIT;
              r_ldop   <= mem_ldop;
              r_lo     <= mem_addr_lo;
              r_wreg   <= mem_wreg;
              r_wraddr <= mem_wraddr;
`ifdef UNALIGNED_LOAD_EN
              r_oldreg <= mem_oldreg;
`endif
            end
          end else begin
            r_we <= 4'h0;
          end
        end
        ST_WAIT: begin
          if (flush) begin
            r_we    <= 4'h0;
            r_state <= dresp_valid ? ST_RUN : ST_DRAIN;
          end else if (dresp_valid) begin
            r_we    <= w_alWe;
            r_waddr <= w_wraddr;
            r_wdata <= w_alData;
            r_state <= ST_RUN;
          end else begin
            r_we <= 4'h0;
          end
        end
        ST_DRAIN: begin
          r_we <= 4'h0;
          if (dresp_valid) begin
            r_state <= ST_RUN;
          end
        end
        default: begin
          r_we    <= 4'h0;
          r_state <= ST_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_writeback.sv
// tb_load_writeback: directed stimulus for load_writeback with a per-cycle reference model.
// The model follows UNALIGNED_LOAD_EN the same way the design does.
module tb_load_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        mem_valid;
  logic [3:0]  mem_wreg;
  logic [4:0]  mem_wraddr;
  logic [31:0] mem_alures;
  logic [2:0]  mem_ldop;
  logic [1:0]  mem_addr_lo;
  logic [31:0] mem_oldreg;
  logic        dresp_valid;
  logic [31:0] dresp_data;
  logic        mem_stall;
  logic [3:0]  we;
  logic [4:0]  waddr;
  logic [31:0] wdata;

  int testsRun    = 0;
  int testsFailed = 0;

  load_writeback dut (
    .clk(clk), .rst(rst), .flush(flush), .mem_valid(mem_valid),
    .mem_wreg(mem_wreg), .mem_wraddr(mem_wraddr), .mem_alures(mem_alures),
    .mem_ldop(mem_ldop), .mem_addr_lo(mem_addr_lo), .mem_oldreg(mem_oldreg),
    .dresp_valid(dresp_valid), .dresp_data(dresp_data),
    .mem_stall(mem_stall), .we(we), .waddr(waddr), .wdata(wdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input string name, input logic [3:0] expWe,
                             input logic [4:0] expAddr, input logic [31:0] expData);
    check32({name, ".we"}, {28'h0, we}, {28'h0, expWe});
    check32({name, ".waddr"}, {27'h0, waddr}, {27'h0, expAddr});
    check32({name, ".wdata"}, wdata, expData);
  endtask

  // Load result from the architectural rules, built byte by byte.
  function automatic void expectLoad(input logic [2:0] op, input logic [1:0] lo,
                                     input logic [3:0] wreg, input logic [31:0] oldv,
                                     input logic [31:0] d, output logic [3:0] weo,
                                     output logic [31:0] dat);
    logic [7:0]  db[4];
    logic [7:0]  rb[4];
    logic [3:0]  m;
    logic [15:0] h;
    int n;
    n = int'(lo);
    for (int i = 0; i < 4; i++) begin
      db[i] = d[8*i +: 8];
      rb[i] = oldv[8*i +: 8];
    end
    m   = 4'b0000;
    weo = wreg;
    dat = d;
    case (op)
      3'd1: dat = {{24{db[n][7]}}, db[n]};
      3'd2: dat = {24'h0, db[n]};
      3'd3: begin h = {db[(n/2)*2+1], db[(n/2)*2]}; dat = {{16{h[15]}}, h}; end
      3'd4: begin h = {db[(n/2)*2+1], db[(n/2)*2]}; dat = {16'h0, h}; end
      3'd5: dat = d;
`ifdef UNALIGNED_LOAD_EN
      3'd6: begin
        for (int k = 0; k < 4; k++) begin
          if (k + 3 - n <= 3) begin
            rb[k+3-n] = db[k];
            m[k+3-n]  = 1'b1;
          end
        end
        weo = wreg & m;
        dat = {rb[3], rb[2], rb[1], rb[0]};
      end
      3'd7: begin
        for (int k = 0; k < 4; k++) begin
          if (k >= n) begin
            rb[k-n] = db[k];
            m[k-n]  = 1'b1;
          end
        end
        weo = wreg & m;
        dat = {rb[3], rb[2], rb[1], rb[0]};
      end
`endif
      default: weo = 4'h0;
    endcase
  endfunction

  // Model: 0 = ready, 1 = load outstanding, 2 = killed load outstanding.
  int          mMode = 0;
  logic [3:0]  eWe   = 4'h0;
  logic [4:0]  eAddr = 5'h0;
  logic [31:0] eData = 32'h0;
  logic [2:0]  sOp;
  logic [1:0]  sLo;
  logic [3:0]  sWreg;
  logic [4:0]  sAddr;
  logic [31:0] sOld;

  always @(negedge clk) begin
    logic expStall;
    if (!rst) begin
      checkOutput("reset", 4'h0, 5'h0, 32'h0);
      check32("reset.mem_stall", {31'h0, mem_stall}, 32'h0);
      mMode = 0;
      eWe   = 4'h0;
      eAddr = 5'h0;
      eData = 32'h0;
    end else begin
      check32("model.we", {28'h0, we}, {28'h0, eWe});
      if (eWe != 4'h0) begin
        check32("model.waddr", {27'h0, waddr}, {27'h0, eAddr});
        check32("model.wdata", wdata, eData);
      end
      case (mMode)
        1:       expStall = !dresp_valid;
        2:       expStall = 1'b1;
        default: expStall = mem_valid && !flush && (mem_ldop != 3'd0) && !dresp_valid;
      endcase
      check32("model.mem_stall", {31'h0, mem_stall}, {31'h0, expStall});
      case (mMode)
        1: begin
          if (flush) begin
            eWe   = 4'h0;
            mMode = dresp_valid ? 0 : 2;
          end else if (dresp_valid) begin
            expectLoad(sOp, sLo, sWreg, sOld, dresp_data, eWe, eData);
            eAddr = sAddr;
            mMode = 0;
          end else begin
            eWe = 4'h0;
          end
        end
        2: begin
          eWe = 4'h0;
          if (dresp_valid) mMode = 0;
        end
        default: begin
          if (mem_valid && !flush) begin
            if (mem_ldop == 3'd0) begin
              eWe   = mem_wreg;
              eAddr = mem_wraddr;
              eData = mem_alures;
            end else if (dresp_valid) begin
              expectLoad(mem_ldop, mem_addr_lo, mem_wreg, mem_oldreg, dresp_data, eWe, eData);
              eAddr = mem_wraddr;
            end else begin
              sOp   = mem_ldop;
              sLo   = mem_addr_lo;
              sWreg = mem_wreg;
              sAddr = mem_wraddr;
              sOld  = mem_oldreg;
              eWe   = 4'h0;
              mMode = 1;
            end
          end else begin
            eWe = 4'h0;
          end
        end
      endcase
    end
  end

  task automatic applyStimulus(input logic v, input logic f, input logic [3:0] wr,
                               input logic [4:0] wa, input logic [31:0] alu,
                               input logic [2:0] op, input logic [1:0] lo,
                               input logic [31:0] old, input logic dv, input logic [31:0] dd);
    mem_valid   = v;
    flush       = f;
    mem_wreg    = wr;
    mem_wraddr  = wa;
    mem_alures  = alu;
    mem_ldop    = op;
    mem_addr_lo = lo;
    mem_oldreg  = old;
    dresp_valid = dv;
    dresp_data  = dd;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic applyIdle();
    applyStimulus(1'b0, 1'b0, 4'h0, 5'd0, 32'h0, 3'd0, 2'd0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic checkStall(input string name, input logic exp);
    #1;
    check32(name, {31'h0, mem_stall}, {31'h0, exp});
  endtask

  initial begin
    int stallCount;
    rst = 1'b0;
    applyIdle();
    repeat (2) @(posedge clk);
    #2;
    checkOutput("reset_state", 4'h0, 5'd0, 32'h0);
    rst = 1'b1;
    step();

    applyStimulus(1'b1, 1'b0, 4'hF, 5'd5, 32'h12345678, 3'd0, 2'd0, 32'h0, 1'b0, 32'h0);
    checkStall("nonload.mem_stall", 1'b0);
    step();
    checkOutput("nonload", 4'hF, 5'd5, 32'h12345678);

    applyStimulus(1'b1, 1'b0, 4'hF, 5'd7, 32'h0, 3'd1, 2'd2, 32'h0, 1'b1, 32'h00800000);
    step();
    checkOutput("lb", 4'hF, 5'd7, 32'hFFFFFF80);
    applyStimulus(1'b1, 1'b0, 4'hF, 5'd7, 32'h0, 3'd2, 2'd2, 32'h0, 1'b1, 32'h00800000);
    step();
    checkOutput("lbu", 4'hF, 5'd7, 32'h00000080);

    applyStimulus(1'b1, 1'b0, 4'hF, 5'd9, 32'h0, 3'd3, 2'd2, 32'h0, 1'b0, 32'h0);
    stallCount = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (mem_stall === 1'b1) stallCount++;
      @(posedge clk);
      #2;
      check32("lh_wait.we", {28'h0, we}, 32'h0);
    end
    dresp_valid = 1'b1;
    dresp_data  = 32'hBEEF0000;
    checkStall("lh_resp.mem_stall", 1'b0);
    step();
    checkOutput("lh_late", 4'hF, 5'd9, 32'hFFFFBEEF);
    check32("lh_late.stall_cycles", stallCount, 32'd3);

    applyStimulus(1'b1, 1'b0, 4'hF, 5'd10, 32'h0, 3'd6, 2'd1, 32'h11223344, 1'b1, 32'hAABBCCDD);
    step();
`ifdef UNALIGNED_LOAD_EN
    checkOutput("lwl", 4'hC, 5'd10, 32'hCCDD3344);
`else
    check32("lwl_disabled.we", {28'h0, we}, 32'h0);
`endif
    applyStimulus(1'b1, 1'b0, 4'hF, 5'd11, 32'h0, 3'd7, 2'd2, 32'h11223344, 1'b1, 32'hAABBCCDD);
    step();
`ifdef UNALIGNED_LOAD_EN
    checkOutput("lwr", 4'h3, 5'd11, 32'h1122AABB);
`else
    check32("lwr_disabled.we", {28'h0, we}, 32'h0);
`endif
    applyStimulus(1'b1, 1'b0, 4'h7, 5'd12, 32'h0, 3'd6, 2'd2, 32'h11223344, 1'b1, 32'hAABBCCDD);
    step();
    applyStimulus(1'b1, 1'b0, 4'hE, 5'd13, 32'h0, 3'd7, 2'd1, 32'h11223344, 1'b1, 32'hAABBCCDD);
    step();

    for (int op = 1; op <= 7; op++) begin
      for (int lo = 0; lo < 4; lo++) begin
        applyStimulus(1'b1, 1'b0, 4'hF, 5'(op + 16), 32'h0, 3'(op), 2'(lo),
                      32'h55667788, 1'b1, 32'h80FF7F01);
        step();
      end
    end

    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 4'(4'h1 << i) | 4'h8, 5'(i * 3), 32'hA5A50000 + 32'(i),
                    3'd0, 2'd0, 32'h0, 1'b0, 32'h0);
      step();
    end

    applyStimulus(1'b1, 1'b0, 4'hF, 5'd14, 32'h0, 3'd5, 2'd0, 32'h0, 1'b0, 32'h0);
    step();
    flush = 1'b1;
    checkStall("flush_wait.mem_stall", 1'b1);
    step();
    applyIdle();
    checkStall("drain.mem_stall", 1'b1);
    step();
    dresp_valid = 1'b1;
    dresp_data  = 32'hDEADBEEF;
    checkStall("drain_resp.mem_stall", 1'b1);
    step();
    check32("drain_resp.we", {28'h0, we}, 32'h0);
    applyIdle();
    checkStall("after_drain.mem_stall", 1'b0);
    step();

    applyStimulus(1'b1, 1'b0, 4'hF, 5'd15, 32'h0, 3'd5, 2'd0, 32'h0, 1'b0, 32'h0);
    step();
    flush       = 1'b1;
    dresp_valid = 1'b1;
    dresp_data  = 32'h01020304;
    step();
    check32("flush_resp.we", {28'h0, we}, 32'h0);
    applyStimulus(1'b1, 1'b0, 4'hF, 5'd16, 32'h0BADF00D, 3'd0, 2'd0, 32'h0, 1'b0, 32'h0);
    step();
    checkOutput("after_flush_resp", 4'hF, 5'd16, 32'h0BADF00D);

    applyStimulus(1'b1, 1'b1, 4'hF, 5'd17, 32'h0, 3'd5, 2'd0, 32'h0, 1'b1, 32'h11111111);
    step();
    check32("flush_run.we", {28'h0, we}, 32'h0);
    applyStimulus(1'b0, 1'b0, 4'hF, 5'd18, 32'h0, 3'd0, 2'd0, 32'h0, 1'b1, 32'h22222222);
    step();
    check32("stray_resp.we", {28'h0, we}, 32'h0);

    applyStimulus(1'b1, 1'b0, 4'hF, 5'd3, 32'hCAFEF00D, 3'd0, 2'd0, 32'h0, 1'b0, 32'h0);
    step();
    applyStimulus(1'b1, 1'b0, 4'hF, 5'd19, 32'h0, 3'd4, 2'd0, 32'h0, 1'b0, 32'h0);
    step();
    step();
    rst = 1'b0;
    #1;
    checkOutput("reset_mid_wait", 4'h0, 5'd0, 32'h0);
    check32("reset_mid_wait.mem_stall", {31'h0, mem_stall}, 32'h0);
    applyIdle();
    step();
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 4'hF, 5'd20, 32'h76543210, 3'd0, 2'd0, 32'h0, 1'b0, 32'h0);
    checkStall("after_reset.mem_stall", 1'b0);
    step();
    checkOutput("after_reset", 4'hF, 5'd20, 32'h76543210);

    applyIdle();
    step();
    step();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
